// File: rtl/alu_share_arb_if.sv
// Request/response bundle between two ALU clients and the shared-ALU arbiter.
//   reqValid/reqReady      : per-requester request handshake (bit i = requester i)
//   reqCntrl/reqUseF7/...  : per-requester ALU operation and operands
//   rspValid/rspReady      : per-requester one-deep response buffer handshake
//   rspResult/rspBranch    : per-requester registered ALU result and branch flag
//   lastGrant              : index of the most recently granted requester
interface alu_share_arb_if;
  logic [1:0]        reqValid;
  logic [1:0]        reqReady;
  logic [1:0][2:0]   reqCntrl;
  logic [1:0]        reqUseF7;
  logic [1:0]        reqInv;
  logic [1:0]        reqLoadStore;
  logic [1:0][31:0]  reqSrcA;
  logic [1:0][31:0]  reqSrcB;
  logic [1:0]        rspValid;
  logic [1:0]        rspReady;
  logic [1:0][31:0]  rspResult;
  logic [1:0]        rspBranch;
  logic              lastGrant;

  // Arbiter side
  modport slave (
    input  reqValid, reqCntrl, reqUseF7, reqInv, reqLoadStore, reqSrcA, reqSrcB,
    input  rspReady,
    output reqReady, rspValid, rspResult, rspBranch, lastGrant
  );

  // Requester/consumer side
  modport master (
    output reqValid, reqCntrl, reqUseF7, reqInv, reqLoadStore, reqSrcA, reqSrcB,
    output rspReady,
    input  reqReady, rspValid, rspResult, rspBranch, lastGrant
  );
endinterface

// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two requesters.
//   clk  : rising-edge clock
//   rstN : asynchronous active-low reset
//   bus  : alu_share_arb_if.slave -- request handshake/operands in, registered
//          per-requester responses and the last-grant pointer out.
// The granted operation executes in the grant cycle; its result lands in that
// requester's one-deep response buffer on the next edge. Ties are broken
// round-robin (ROUND_ROBIN=1) or always in favour of requester 0.

module alu (
  input  logic [2:0]  aluCntrl,
  input  logic        useF7,
  input  logic        inv,
  input  logic        loadStore,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  output logic [31:0] aluResult,
  output logic        branchFlag
);
  logic [2:0]         op;
  logic               isSub;
  logic signed [31:0] sA;
  logic signed [31:0] sB;
  logic [4:0]         shamt;
  logic [31:0]        diff;
  logic               lt;

  always_comb begin
    // Address generation always adds, regardless of the funct7 select.
    op         = loadStore ? 3'b000 : aluCntrl;
    isSub      = useF7 && !loadStore;
    sA         = srcA;
    sB         = srcB;
    shamt      = srcB[4:0];
    diff       = srcA - srcB;
    lt         = 1'b0;
    aluResult  = '0;
    branchFlag = 1'b0;
    case (op)
      3'b000: begin
        if (isSub) begin
          aluResult  = diff;
          branchFlag = (diff == 32'd0) ^ inv;
        end else begin
          aluResult  = srcA + srcB;
        end
      end
      3'b001: aluResult = srcA << shamt;
      3'b010: begin
        lt         = sA < sB;
        aluResult  = {31'd0, lt};
        branchFlag = lt ^ inv;
      end
      3'b011: begin
        lt         = srcA < srcB;
        aluResult  = {31'd0, lt};
        branchFlag = lt ^ inv;
      end
      3'b100: aluResult = srcA ^ srcB;
      3'b101: begin
        // Kept as separate branches so the arithmetic shift stays signed.
        if (useF7) aluResult = $unsigned(sA >>> shamt);
        else       aluResult = srcA >> shamt;
      end
      3'b110: aluResult = srcA | srcB;
      3'b111: aluResult = srcA & srcB;
      default: aluResult = '0;
    endcase
  end
endmodule

module alu_share_arb #(
  parameter logic ROUND_ROBIN = 1'b1
) (
  input  logic             clk,
  input  logic             rstN,
  alu_share_arb_if.slave   bus
);
  logic [1:0]       eligible;
  logic [1:0]       grant;
  logic             sel;
  logic [31:0]      aluResult;
  logic             branchFlag;

  logic [1:0]       rspValid_q,  rspValid_d;
  logic [1:0][31:0] rspResult_q, rspResult_d;
  logic [1:0]       rspBranch_q, rspBranch_d;
  logic             lastGrant_q, lastGrant_d;

  always_comb begin
    // A full buffer that drains this cycle can accept a new result.
    eligible = bus.reqValid & (~rspValid_q | bus.rspReady);
    grant    = 2'b00;
    if (!rstN) begin
      grant = 2'b00;
    end else if (&eligible) begin
      grant = (ROUND_ROBIN && !lastGrant_q) ? 2'b10 : 2'b01;
    end else begin
      grant = eligible;
    end
  end

  // With no grant the mux defaults to requester 0; the ALU output is unused.
  assign sel = grant[1];

  alu u_alu (
    .aluCntrl   (bus.reqCntrl[sel]),
    .useF7      (bus.reqUseF7[sel]),
    .inv        (bus.reqInv[sel]),
    .loadStore  (bus.reqLoadStore[sel]),
    .srcA       (bus.reqSrcA[sel]),
    .srcB       (bus.reqSrcB[sel]),
    .aluResult  (aluResult),
    .branchFlag (branchFlag)
  );

  always_comb begin
    rspValid_d  = rspValid_q;
    rspResult_d = rspResult_q;
    rspBranch_d = rspBranch_q;
    for (int i = 0; i < 2; i++) begin
      // A grant wins over a simultaneous drain: the buffer refills.
      rspValid_d[i] = grant[i] | (rspValid_q[i] & ~bus.rspReady[i]);
      if (grant[i]) begin
        rspResult_d[i] = aluResult;
        rspBranch_d[i] = branchFlag;
      end
    end
    lastGrant_d = (|grant) ? grant[1] : lastGrant_q;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rspValid_q  <= 2'b00;
      rspResult_q <= '0;
      rspBranch_q <= 2'b00;
      lastGrant_q <= 1'b1;
    end else begin
      rspValid_q  <= rspValid_d;
      rspResult_q <= rspResult_d;
      rspBranch_q <= rspBranch_d;
      lastGrant_q <= lastGrant_d;
    end
  end

  assign bus.reqReady  = grant;
  assign bus.rspValid  = rspValid_q;
  assign bus.rspResult = rspResult_q;
  assign bus.rspBranch = rspBranch_q;
  assign bus.lastGrant = lastGrant_q;
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin instance and a
// fixed-priority instance, checked against hand-computed values.
module tb_alu_share_arb;
  logic clk;
  logic rstN;
  int   n_cmp;
  int   n_err;

  alu_share_arb_if bus_rr ();
  alu_share_arb_if bus_fp ();

  alu_share_arb #(.ROUND_ROBIN(1'b1)) dut_rr (.clk(clk), .rstN(rstN), .bus(bus_rr.slave));
  alu_share_arb #(.ROUND_ROBIN(1'b0)) dut_fp (.clk(clk), .rstN(rstN), .bus(bus_fp.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int idx, input logic [2:0] c, input logic f7, input logic iv,
                         input logic ls, input logic [31:0] a, input logic [31:0] b);
    bus_rr.reqCntrl[idx]     = c;
    bus_rr.reqUseF7[idx]     = f7;
    bus_rr.reqInv[idx]       = iv;
    bus_rr.reqLoadStore[idx] = ls;
    bus_rr.reqSrcA[idx]      = a;
    bus_rr.reqSrcB[idx]      = b;
  endtask

  initial begin
    logic [1:0] exp_g;
    n_cmp = 0;
    n_err = 0;
    rstN  = 1'b0;
    bus_rr.reqValid = 2'b11;  bus_rr.rspReady = 2'b11;
    bus_rr.reqCntrl = '0;     bus_rr.reqUseF7 = '0;  bus_rr.reqInv = '0;
    bus_rr.reqLoadStore = '0; bus_rr.reqSrcA = '0;   bus_rr.reqSrcB = '0;
    bus_fp.reqValid = 2'b00;  bus_fp.rspReady = 2'b11;
    bus_fp.reqCntrl = '0;     bus_fp.reqUseF7 = '0;  bus_fp.reqInv = '0;
    bus_fp.reqLoadStore = '0; bus_fp.reqSrcA = '0;   bus_fp.reqSrcB = '0;

    // Reset state, with requests pending
    #12;
    chk("rst_reqReady", bus_rr.reqReady, 2'b00);
    chk("rst_rspValid", bus_rr.rspValid, 2'b00);
    chk("rst_result0", bus_rr.rspResult[0], 32'd0);
    chk("rst_result1", bus_rr.rspResult[1], 32'd0);
    chk("rst_branch", bus_rr.rspBranch, 2'b00);
    chk("rst_lastGrant", bus_rr.lastGrant, 1'b1);
    bus_rr.reqValid = 2'b00;
    step();
    rstN = 1'b1;

    // Requester 0 alone: 5 + 7
    set_req(0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd5, 32'd7);
    bus_rr.reqValid = 2'b01;
    #1 chk("t1_reqReady", bus_rr.reqReady, 2'b01);
    step();
    chk("t1_rspValid", bus_rr.rspValid, 2'b01);
    chk("t1_result0", bus_rr.rspResult[0], 32'd12);
    chk("t1_lastGrant", bus_rr.lastGrant, 1'b0);
    bus_rr.reqValid = 2'b00;
    step();
    chk("t1_drained", bus_rr.rspValid, 2'b00);
    chk("t1_idle_lastGrant", bus_rr.lastGrant, 1'b0);

    // Requester 1 alone: 9 - 9 = 0, branch taken
    set_req(1, 3'b000, 1'b1, 1'b0, 1'b0, 32'd9, 32'd9);
    bus_rr.reqValid = 2'b10;
    #1 chk("t1b_reqReady", bus_rr.reqReady, 2'b10);
    step();
    chk("t1b_rspValid", bus_rr.rspValid, 2'b10);
    chk("t1b_result1", bus_rr.rspResult[1], 32'd0);
    chk("t1b_branch1", bus_rr.rspBranch[1], 1'b1);
    chk("t1b_lastGrant", bus_rr.lastGrant, 1'b1);

    // Both requesting every cycle: alternate starting at requester 0
    set_req(0, 3'b100, 1'b0, 1'b0, 1'b0, 32'hF0F0_0000, 32'h0FF0_00FF);
    bus_rr.reqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      #1 chk("rr_reqReady", bus_rr.reqReady, exp_g);
      step();
      chk("rr_rspValid", bus_rr.rspValid, exp_g);
      chk("rr_lastGrant", bus_rr.lastGrant, exp_g[1]);
      if (exp_g == 2'b01) begin
        chk("rr_result0", bus_rr.rspResult[0], 32'hFF00_00FF);
      end else begin
        chk("rr_result1", bus_rr.rspResult[1], (k == 1) ? 32'd0 : 32'd11);
        chk("rr_branch1", bus_rr.rspBranch[1], (k == 1) ? 1'b1 : 1'b0);
      end
      if (k == 1) set_req(1, 3'b000, 1'b1, 1'b0, 1'b0, 32'd20, 32'd9);
    end

    // Requester 1 blocked by its full buffer; requester 0 streams
    set_req(1, 3'b011, 1'b0, 1'b0, 1'b0, 32'd3, 32'd5);
    bus_rr.rspReady = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1 chk("blk_reqReady", bus_rr.reqReady, 2'b01);
      step();
      chk("blk_rspValid", bus_rr.rspValid, 2'b11);
      chk("blk_result1_hold", bus_rr.rspResult[1], 32'd11);
      chk("blk_branch1_hold", bus_rr.rspBranch[1], 1'b0);
      chk("blk_lastGrant", bus_rr.lastGrant, 1'b0);
    end
    bus_rr.rspReady = 2'b11;
    #1 chk("drain_reqReady", bus_rr.reqReady, 2'b10);
    step();
    chk("drain_rspValid", bus_rr.rspValid, 2'b10);
    chk("drain_result1", bus_rr.rspResult[1], 32'd1);
    chk("drain_branch1", bus_rr.rspBranch[1], 1'b1);
    chk("drain_lastGrant", bus_rr.lastGrant, 1'b1);
    bus_rr.reqValid = 2'b00;

    // Fixed priority: requester 0 always wins the tie
    bus_fp.reqCntrl = {3'b111, 3'b111};
    bus_fp.reqSrcA  = {32'hFF00_FF00, 32'hFF00_FF00};
    bus_fp.reqSrcB  = {32'h0F0F_0F0F, 32'h0F0F_0F0F};
    bus_fp.reqValid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1 chk("fp_reqReady", bus_fp.reqReady, 2'b01);
      step();
      chk("fp_lastGrant", bus_fp.lastGrant, 1'b0);
      chk("fp_result0", bus_fp.rspResult[0], 32'h0F00_0F00);
    end
    bus_fp.reqValid = 2'b00;

    // Shifts, force-add, compares on requester 0 back to back
    set_req(0, 3'b101, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h24);
    bus_rr.reqValid = 2'b01;
    step();
    chk("sra", bus_rr.rspResult[0], 32'hF800_0000);
    set_req(0, 3'b101, 1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h24);
    step();
    chk("srl", bus_rr.rspResult[0], 32'h0800_0000);
    set_req(0, 3'b101, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'h24);
    step();
    chk("loadStore_add", bus_rr.rspResult[0], 32'h8000_0024);
    chk("loadStore_branch", bus_rr.rspBranch[0], 1'b0);
    set_req(0, 3'b010, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("slt_result", bus_rr.rspResult[0], 32'd1);
    chk("slt_branch", bus_rr.rspBranch[0], 1'b1);
    set_req(0, 3'b011, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1);
    step();
    chk("sltu_result", bus_rr.rspResult[0], 32'd0);
    chk("sltu_inv_branch", bus_rr.rspBranch[0], 1'b1);
    set_req(0, 3'b001, 1'b0, 1'b0, 1'b0, 32'd3, 32'h21);
    step();
    chk("sll", bus_rr.rspResult[0], 32'd6);
    chk("stream_rspValid", bus_rr.rspValid, 2'b01);
    bus_rr.reqValid = 2'b00;
    step();

    // Reset the cycle after an accept
    set_req(0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1, 32'd2);
    bus_rr.reqValid = 2'b01;
    #1 chk("rst2_reqReady", bus_rr.reqReady, 2'b01);
    step();
    chk("rst2_accepted", bus_rr.rspValid, 2'b01);
    chk("rst2_result0", bus_rr.rspResult[0], 32'd3);
    bus_rr.reqValid = 2'b00;
    rstN = 1'b0;
    #1;
    chk("rst2_rspValid", bus_rr.rspValid, 2'b00);
    chk("rst2_result0_clr", bus_rr.rspResult[0], 32'd0);
    chk("rst2_lastGrant", bus_rr.lastGrant, 1'b1);
    step();
    step();
    rstN = 1'b1;
    step();
    chk("rst2_after_release", bus_rr.rspValid, 2'b00);
    bus_rr.reqValid = 2'b11;
    #1 chk("rst2_tie_reqReady", bus_rr.reqReady, 2'b01);
    step();
    chk("rst2_tie_lastGrant", bus_rr.lastGrant, 1'b0);
    bus_rr.reqValid = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_share_arb.md
Name: alu_share_arb

Overview:
Two-requester arbiter that shares one instance of the team's combinational `alu` (aluCntrl/useF7/inv/loadStore/srcA/srcB -> aluResult/branchFlag) between two clients. Typical clients are the main execute stage (requester 0) and the branch/AGU helper path (requester 1). Requests use a valid/ready handshake. The selected operation is executed in the grant cycle, and the result is registered into a one-deep response buffer per requester. Arbitration is round-robin, or fixed priority by parameter.

Parameters:
ROUND_ROBIN, 1, 1 = round-robin between requesters; 0 = fixed priority, requester 0 always wins a tie

Ports:
clk  input  1  clock, rising edge
rstN  input  1  asynchronous active-low reset
reqValid  input  2  per-requester request valid, bit i = requester i
reqReady  output  2  per-requester request accepted this cycle (combinational grant)
reqCntrl  input  2x3  per-requester ALU operation code
reqUseF7  input  2  per-requester funct7 select (sub / arithmetic shift)
reqInv  input  2  per-requester branch-flag invert
reqLoadStore  input  2  per-requester force-add (address generation)
reqSrcA  input  2x32  per-requester operand A
reqSrcB  input  2x32  per-requester operand B
rspValid  output  2  per-requester response buffer full
rspReady  input  2  per-requester consumer accepts response
rspResult  output  2x32  per-requester registered ALU result
rspBranch  output  2  per-requester registered branch flag
lastGrant  output  1  index of the most recently granted requester

Behaviour:
- Reset while rstN is low:
  - rspValid = 0, rspResult = 0, rspBranch = 0.
  - lastGrant = 1, so requester 0 wins the first tie.
  - reqReady = 0.
  - Any buffered response is discarded. Reset mid-operation requires no replay.
- Eligibility: eligible[i] = reqValid[i] && (!rspValid[i] || rspReady[i]). A full buffer that is draining in the same cycle counts as free.
- Grant (combinational, at most one bit per cycle):
  - Only one requester eligible: grant it.
  - Both eligible, ROUND_ROBIN=1: grant the requester != lastGrant.
  - Both eligible, ROUND_ROBIN=0: grant requester 0.
  - reqReady = grant. reqReady may depend on reqValid; requesters must not make reqValid depend on reqReady.
- Datapath: one `alu` instance. Operands and control are muxed from the granted requester, or from requester 0 when there is no grant (the output is then ignored).
- On a clock edge with grant[i]:
  - rspResult[i] <= aluResult, rspBranch[i] <= branchFlag.
  - rspValid[i] <= 1, lastGrant <= i.
- Latency: an accept in cycle N gives rspValid in cycle N+1.
- Throughput: one operation per cycle in total. One requester alone with rspReady held high receives back-to-back results every cycle.
- Response drain: rspValid[i] && rspReady[i] with no new grant to i clears rspValid[i] next edge. A simultaneous drain and grant keeps rspValid[i]=1 and loads the new result.
- rspResult[i] and rspBranch[i] hold stable while rspValid[i]=1 and not drained. Consumers may sample them at any time.
- lastGrant changes only on a grant. Idle cycles do not move the pointer.
- The losing requester must hold reqValid and all request fields stable until accepted. Acceptance is guaranteed within 2 cycles when its response buffer is free and ROUND_ROBIN=1.
- ALU semantics (bench model):
  - loadStore forces op 000 add.
  - 000: add, or sub when useF7=1. For sub, branchFlag = (result==0) XOR inv.
  - 001: sll by srcB[4:0].
  - 010: slt, 011: sltu. Result is 0/1; branchFlag = bit0 XOR inv.
  - 100: xor, 110: or, 111: and.
  - 101: srl, or sra when useF7=1.
  - branchFlag = 0 for every other case.

Test Plan:
- Reset, then req0 only: cntrl=000, useF7=0, A=5, B=7 -> reqReady=01 same cycle; next cycle rspValid=01, rspResult[0]=12, lastGrant=0.
- Both request every cycle, rspReady=11, ROUND_ROBIN=1 -> grants alternate 01,10,01,10 starting with requester 0. Each response matches its own operands. req1 (000, useF7=1, inv=0, A=B=9) gives rspBranch[1]=1, result 0.
- rspReady[1]=0 with rspValid[1]=1, req1 and req0 both valid -> requester 1 is not granted; requester 0 is granted every cycle; rspResult[1] stays stable. Raising rspReady[1] gives requester 1 the grant in the same cycle as the drain.
- ROUND_ROBIN=0, both valid for 4 cycles -> reqReady=01 for all 4 cycles; lastGrant=0.
- req0: cntrl=101, useF7=1, A=0x80000000, B=0x24 -> rspResult[0]=0xF8000000 (shift by 4). Same request with loadStore=1 -> 0x80000024.
- Assert rstN low the cycle after an accept -> rspValid=00 immediately and stays 00 after reset release. The next tie grants requester 0.
